uart_arbiter: RTL and testbench
===============================

UART_ARBITER -- requirements
Module: uart_arbiter

Interface
REQ-001 Parameter: CLK_PER_HALF_BIT, default 434; passed through to the UART timing only and has no function inside this block.
REQ-002 Port: clk  in  1  system clock; all logic on its rising edge.
REQ-003 Port: rst  in  1  asynchronous, active-high reset.
REQ-004 Ports: reqN_go  in  1  (N=0,1) one-cycle transfer request pulse.
REQ-005 Ports: reqN_rors  in  1  direction sampled with reqN_go; 1=send, 0=receive.
REQ-006 Ports: reqN_txdata  in  8  send byte sampled with reqN_go.
REQ-007 Ports: reqN_lock  in  1  level; while high after a grant, requester N keeps ownership.
REQ-008 Ports: reqN_done  out  1  one-cycle completion pulse to requester N.
REQ-009 Ports: reqN_rxdata  out  8  received byte; valid from the reqN_done cycle until N's next done.
REQ-010 Port: uart_go  out  1  one-cycle start pulse to the shared UART unit.
REQ-011 Port: rors  out  1  direction to the UART unit; 1=send.
REQ-012 Port: txdata  out  8  send byte to the UART unit.
REQ-013 Port: uart_done  in  1  one-cycle completion pulse from the UART unit.
REQ-014 Port: rxdata  in  8  received byte from the UART unit; valid in the uart_done cycle.
REQ-015 Port: busy  out  1  high whenever state is not IDLE.
REQ-016 Port: owner  out  1  index of the requester currently or last granted.

Function
REQ-017 Each requester has a pending flag, a latched direction and a latched byte; a reqN_go pulse sets the flag and captures reqN_rors and reqN_txdata.
- reqN_go while N is pending: ignored; the first captured request is kept.
REQ-018 States: IDLE, ISSUE, WAIT, DONE.
REQ-019 IDLE transitions:
- Any pending flag set -> select a winner, go to ISSUE.
- Nothing pending -> stay in IDLE.
- A request pulsed in cycle t is selectable from cycle t+1.
REQ-020 Winner selection (round-robin):
- Only one requester pending -> it wins.
- Both pending -> the requester that is not owner wins.
- Lock override: owner's lock high and owner pending -> owner wins.
REQ-021 ISSUE: exactly one cycle.
- uart_go=1; rors and txdata driven from the winner's latch.
- owner updated to the winner.
- Next state WAIT.
REQ-022 WAIT: rors and txdata held stable; stay until uart_done=1, then go to DONE.
REQ-023 DONE: exactly one cycle.
- reqN_done=1 for owner only.
- Receive transfers: reqN_rxdata loaded with the rxdata value captured in the uart_done cycle.
- Owner's pending flag cleared.
- Next state IDLE.
REQ-024 Latency: uncontended request pulsed in cycle t -> uart_go in cycle t+2; reqN_done is 1 cycle after uart_done.
REQ-025 Simultaneous req0_go and req1_go with no lock: winner is the non-owner; the other stays pending and is served next.
REQ-026 reqN_go arriving in the same cycle the owner's pending flag is cleared (DONE) is captured as a new request and is not lost.
REQ-027 uart_done outside WAIT is ignored.
REQ-028 At most one uart_go per transfer; uart_go never asserted outside ISSUE.

Reset
REQ-029 rst asserted (asynchronously) forces the following until rst deasserts; the first active edge after deassertion starts from IDLE:
- state IDLE;
- all pending flags 0;
- uart_go, reqN_done and busy 0;
- rors, txdata and reqN_rxdata 0;
- owner 1, so requester 0 wins the first contention.
REQ-030 Reset mid-transfer abandons the transfer; no done pulse is generated.

Structure
REQ-031 The state enum and the requester count constant (2) are placed in a shared package uart_pkg.
REQ-032 Per-requester pending/latch logic is one sub-module, uart_req_slot, instantiated twice.

Verification
REQ-033 Single send: req0_go, rors=1, txdata=8'h41 -> uart_go 2 cycles later with txdata=8'h41; model uart_done after 10 cycles -> req0_done 1 cycle after it.
REQ-034 Single receive: req1_go, rors=0; model returns rxdata=8'h5A with uart_done -> req1_done with req1_rxdata=8'h5A.
REQ-035 Contention: both go pulses in the same cycle after reset -> req0 served first, then req1; two uart_go pulses total.
REQ-036 Lock: req0_lock=1, req0 re-requests every transfer while req1 is pending -> req0 wins each time; req0_lock deasserted -> req1 served next.
REQ-037 Duplicate request: second req0_go while req0 is pending with txdata=8'hFF -> only one transfer, carrying the first byte.
REQ-038 Reset in WAIT: rst pulsed -> busy=0 and no done pulse; new request completes normally.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART arbiter slice.
//   NUM_REQ     : number of requesters sharing the UART unit (2)
//   state_t     : arbiter FSM states (IDLE, ISSUE, WAIT, DONE)
//   pick_winner : round-robin winner selection with owner lock override
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Returns the index of the requester to grant. Only meaningful when at
    // least one of p0/p1 is set. With both pending, the requester that is not
    // the current owner wins, unless the owner holds its lock.
    function automatic logic pick_winner(
        input logic p0,
        input logic p1,
        input logic owner,
        input logic owner_lock
    );
        logic w;
        if (p0 && p1) begin
            w = owner_lock ? owner : ~owner;
        end else begin
            w = p1;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_req_slot.sv
// -----------------------------------------------------------------------------
// uart_req_slot
// Per-requester pending flag with latched direction and send byte.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   go           : one-cycle request pulse
//   req_rors     : direction sampled with go (1=send, 0=receive)
//   req_txdata   : send byte sampled with go
//   clear        : arbiter is completing this requester's transfer this cycle
//   pending      : request captured and not yet completed
//   rors, txdata : latched direction / byte of the pending request
// -----------------------------------------------------------------------------
module uart_req_slot
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       req_rors,
    input  logic [7:0] req_txdata,
    input  logic       clear,
    output logic       pending,
    output logic       rors,
    output logic [7:0] txdata
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
            rors    <= 1'b0;
            txdata  <= 8'h00;
        end else if (clear) begin
            // A go arriving in the completion cycle becomes the next request.
            pending <= go;
            if (go) begin
                rors   <= req_rors;
                txdata <= req_txdata;
            end
        end else if (go && !pending) begin
            // A go while already pending is dropped; the first request stands.
            pending <= 1'b1;
            rors    <= req_rors;
            txdata  <= req_txdata;
        end
    end

endmodule

// File: rtl/uart_arbiter.sv
// -----------------------------------------------------------------------------
// uart_arbiter
// Shares one UART unit between two requesters with round-robin arbitration
// and an optional per-requester lock that lets the owner keep the unit.
//
// Handshake: a requester pulses reqN_go for one cycle with reqN_rors/txdata;
// the arbiter answers with a one-cycle reqN_done pulse when the transfer is
// over. Towards the UART unit, uart_go is a one-cycle start pulse and the unit
// answers with a one-cycle uart_done pulse carrying rxdata. rors/txdata are
// stable from uart_go until uart_done. No backpressure exists on either side.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   reqN_go/rors/txdata/lock : requester N request inputs (N=0,1)
//   reqN_done, reqN_rxdata   : requester N completion pulse and received byte
//   uart_go, rors, txdata    : start pulse, direction and byte to the UART
//   uart_done, rxdata        : completion pulse and received byte from UART
//   busy                     : arbiter not idle
//   owner                    : requester currently or last granted
//   state                    : FSM state, for observation
// -----------------------------------------------------------------------------
module uart_arbiter
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_go,
    input  logic       req0_rors,
    input  logic [7:0] req0_txdata,
    input  logic       req0_lock,
    output logic       req0_done,
    output logic [7:0] req0_rxdata,
    input  logic       req1_go,
    input  logic       req1_rors,
    input  logic [7:0] req1_txdata,
    input  logic       req1_lock,
    output logic       req1_done,
    output logic [7:0] req1_rxdata,
    output logic       uart_go,
    output logic       rors,
    output logic [7:0] txdata,
    input  logic       uart_done,
    input  logic [7:0] rxdata,
    output logic       busy,
    output logic       owner,
    output state_t     state
);

    // The bit timing belongs to the UART unit; this block only carries the
    // parameter so both can be configured from one place.
    if (CLK_PER_HALF_BIT > 0) begin : g_timing_param
    end

    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] slot_rors;
    logic [7:0]         slot_txdata [NUM_REQ];
    logic               clear0;
    logic               clear1;
    logic               owner_lock;
    logic               winner;

    // The owner's pending flag drops at the end of the DONE cycle.
    assign clear0 = (state == DONE) && !owner;
    assign clear1 = (state == DONE) &&  owner;

    uart_req_slot u_slot0 (
        .clk        (clk),
        .rst        (rst),
        .go         (req0_go),
        .req_rors   (req0_rors),
        .req_txdata (req0_txdata),
        .clear      (clear0),
        .pending    (pending[0]),
        .rors       (slot_rors[0]),
        .txdata     (slot_txdata[0])
    );

    uart_req_slot u_slot1 (
        .clk        (clk),
        .rst        (rst),
        .go         (req1_go),
        .req_rors   (req1_rors),
        .req_txdata (req1_txdata),
        .clear      (clear1),
        .pending    (pending[1]),
        .rors       (slot_rors[1]),
        .txdata     (slot_txdata[1])
    );

    assign owner_lock = owner ? req1_lock : req0_lock;
    assign winner     = pick_winner(pending[0], pending[1], owner, owner_lock);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= 1'b1;   // requester 0 wins the first contention
            uart_go     <= 1'b0;
            rors        <= 1'b0;
            txdata      <= 8'h00;
            req0_done   <= 1'b0;
            req1_done   <= 1'b0;
            req0_rxdata <= 8'h00;
            req1_rxdata <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (|pending) begin
                        // Outputs for ISSUE are registered on the way in.
                        owner   <= winner;
                        uart_go <= 1'b1;
                        rors    <= slot_rors[winner];
                        txdata  <= slot_txdata[winner];
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    uart_go <= 1'b0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (uart_done) begin
                        state <= DONE;
                        if (owner) begin
                            req1_done <= 1'b1;
                            if (!rors) req1_rxdata <= rxdata;
                        end else begin
                            req0_done <= 1'b1;
                            if (!rors) req0_rxdata <= rxdata;
                        end
                    end
                end
                DONE: begin
                    req0_done <= 1'b0;
                    req1_done <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_arbiter
// Self-checking bench for uart_arbiter: a UART responder model, a monitor
// that checks every grant and completion against expectation queues, a
// table of single transfers and hand-written multi-cycle sequences.
// -----------------------------------------------------------------------------
module tb_uart_arbiter;
    import uart_pkg::*;

    localparam int W = 9;  // {rors, byte}

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_go, req0_rors, req0_lock;
    logic [7:0] req0_txdata;
    logic       req1_go, req1_rors, req1_lock;
    logic [7:0] req1_txdata;
    logic       req0_done, req1_done;
    logic [7:0] req0_rxdata, req1_rxdata;
    logic       uart_go, rors, busy, owner;
    logic [7:0] txdata;
    logic       ud_model, ud_stray;
    logic [7:0] rx_bus;
    state_t     dbg_state;

    always #5 clk = ~clk;

    uart_arbiter #(.CLK_PER_HALF_BIT(434)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_go     (req0_go),
        .req0_rors   (req0_rors),
        .req0_txdata (req0_txdata),
        .req0_lock   (req0_lock),
        .req0_done   (req0_done),
        .req0_rxdata (req0_rxdata),
        .req1_go     (req1_go),
        .req1_rors   (req1_rors),
        .req1_txdata (req1_txdata),
        .req1_lock   (req1_lock),
        .req1_done   (req1_done),
        .req1_rxdata (req1_rxdata),
        .uart_go     (uart_go),
        .rors        (rors),
        .txdata      (txdata),
        .uart_done   (ud_model | ud_stray),
        .rxdata      (rx_bus),
        .busy        (busy),
        .owner       (owner),
        .state       (dbg_state)
    );

    // Scoreboard: per-requester expected {rors, byte}, expected grant order,
    // and bytes the UART model returns for receive transfers.
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    logic         ord_q[$];
    logic [7:0]   rx_q[$];

    int total = 0;
    int bad   = 0;
    int go_cnt = 0;
    int done_cnt = 0;
    int resp_delay = 10;
    logic prev_ud = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // ---------------- monitor ----------------
    logic         mon_idx;
    logic [W-1:0] mon_e;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (uart_go) go_cnt++;
            if (req0_done || req1_done) done_cnt++;
            if (!rst) begin
                if (uart_go) begin
                    if (ord_q.size() == 0) begin
                        fail_now("unexpected_uart_go");
                    end else begin
                        mon_idx = ord_q.pop_front();
                        check("grant_owner", 32'(owner), 32'(mon_idx));
                        if ((mon_idx == 1'b0 && exp_q0.size() == 0) ||
                            (mon_idx == 1'b1 && exp_q1.size() == 0)) begin
                            fail_now("grant_without_request");
                        end else begin
                            mon_e = (mon_idx == 1'b0) ? exp_q0[0] : exp_q1[0];
                            check("issue_rors", 32'(rors), 32'(mon_e[8]));
                            if (mon_e[8]) check("issue_txdata", 32'(txdata), 32'(mon_e[7:0]));
                        end
                    end
                end
                if (req0_done || req1_done) begin
                    check("single_done", 32'(req0_done & req1_done), 32'(0));
                    check("done_after_uart_done", 32'(prev_ud), 32'(1));
                end
                if (req0_done) begin
                    if (exp_q0.size() == 0) fail_now("unexpected_req0_done");
                    else begin
                        mon_e = exp_q0.pop_front();
                        if (!mon_e[8]) check("req0_rxdata", 32'(req0_rxdata), 32'(mon_e[7:0]));
                    end
                end
                if (req1_done) begin
                    if (exp_q1.size() == 0) fail_now("unexpected_req1_done");
                    else begin
                        mon_e = exp_q1.pop_front();
                        if (!mon_e[8]) check("req1_rxdata", 32'(req1_rxdata), 32'(mon_e[7:0]));
                    end
                end
            end
            prev_ud = ud_model | ud_stray;
        end
    end

    // ---------------- UART responder model ----------------
    logic resp_rors;
    logic resp_abort;

    initial begin
        ud_model = 1'b0;
        rx_bus   = 8'h00;
        forever begin
            @(negedge clk);
            if (uart_go && !rst) begin
                resp_rors  = rors;
                resp_abort = 1'b0;
                for (int k = 0; k < resp_delay; k++) begin
                    @(negedge clk);
                    if (rst) begin
                        resp_abort = 1'b1;
                        break;
                    end
                end
                if (!resp_abort) begin
                    ud_model = 1'b1;
                    if (!resp_rors && rx_q.size() > 0) rx_bus = rx_q.pop_front();
                    else rx_bus = 8'($urandom_range(0, 255));
                    @(negedge clk);
                    ud_model = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic expect_xfer(input int idx, input logic r, input logic [7:0] d);
        logic i1;
        i1 = 1'(idx);
        ord_q.push_back(i1);
        if (i1 == 1'b0) exp_q0.push_back({r, d});
        else            exp_q1.push_back({r, d});
        if (!r) rx_q.push_back(d);
    endtask

    task automatic set_req(input int idx, input logic r, input logic [7:0] d);
        if (idx == 0) begin
            req0_go = 1'b1; req0_rors = r; req0_txdata = d;
        end else begin
            req1_go = 1'b1; req1_rors = r; req1_txdata = d;
        end
    endtask

    task automatic drop_go();
        req0_go = 1'b0;
        req1_go = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while ((busy || ord_q.size() != 0 || exp_q0.size() != 0 || exp_q1.size() != 0)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL %s_timeout: still busy after %0d cycles, want idle", tag, n);
        end
    endtask

    // sel 0: uart_go, sel 1: req0_done
    task automatic wait_out(input int sel, input int budget, input string tag);
        int n;
        logic seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            seen = (sel == 0) ? uart_go : req0_done;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s_timeout: no pulse in %0d cycles, want one", tag, budget);
        end
    endtask

    // ---------------- table ----------------
    typedef struct {
        int         idx;
        logic       rors;
        logic [7:0] data;
        int         delay;
    } vec_t;

    vec_t vecs[8];

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int g0;
        int d0;
        logic [7:0] lock_bytes[4];

        rst = 1'b1;
        ud_stray = 1'b0;
        req0_go = 0; req0_rors = 0; req0_txdata = 0; req0_lock = 0;
        req1_go = 0; req1_rors = 0; req1_txdata = 0; req1_lock = 0;

        vecs[0] = '{0, 1'b1, 8'h41, 10};
        vecs[1] = '{1, 1'b0, 8'h5A, 10};
        vecs[2] = '{0, 1'b0, 8'hC3, 1};
        vecs[3] = '{1, 1'b1, 8'h7E, 3};
        vecs[4] = '{0, 1'b1, 8'h00, 12};
        vecs[5] = '{1, 1'b0, 8'hFF, 2};
        vecs[6] = '{0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), $urandom_range(1, 12)};
        vecs[7] = '{1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), $urandom_range(1, 12)};

        // ---- reset values ----
        repeat (3) @(negedge clk);
        check("rst_busy",    32'(busy), 32'(0));
        check("rst_uart_go", 32'(uart_go), 32'(0));
        check("rst_done",    32'({req0_done, req1_done}), 32'(0));
        check("rst_rors",    32'(rors), 32'(0));
        check("rst_txdata",  32'(txdata), 32'(0));
        check("rst_rxdata",  32'({req0_rxdata, req1_rxdata}), 32'(0));
        check("rst_owner",   32'(owner), 32'(1));
        check("rst_state",   32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        @(negedge clk);

        // ---- contention right after reset: req0 first, then req1 ----
        resp_delay = 4;
        g0 = go_cnt;
        expect_xfer(0, 1'b1, 8'h10);
        expect_xfer(1, 1'b1, 8'h20);
        set_req(0, 1'b1, 8'h10);
        set_req(1, 1'b1, 8'h20);
        @(negedge clk);
        drop_go();
        wait_idle(200, "contention");
        check("contention_go_count", 32'(go_cnt - g0), 32'(2));

        // ---- table of single transfers ----
        for (int i = 0; i < 8; i++) begin
            resp_delay = vecs[i].delay;
            expect_xfer(vecs[i].idx, vecs[i].rors, vecs[i].data);
            set_req(vecs[i].idx, vecs[i].rors, vecs[i].data);
            @(negedge clk);
            drop_go();
            check("latency_t1_go", 32'(uart_go), 32'(0));
            @(negedge clk);
            check("latency_t2_go", 32'(uart_go), 32'(1));
            check("busy_in_issue", 32'(busy), 32'(1));
            wait_idle(200, "table");
            if (!vecs[i].rors) begin
                if (vecs[i].idx == 0) check("rx0_hold", 32'(req0_rxdata), 32'(vecs[i].data));
                else                  check("rx1_hold", 32'(req1_rxdata), 32'(vecs[i].data));
            end
            repeat (2) @(negedge clk);
        end

        // ---- lock: req0 keeps the unit while req1 waits ----
        lock_bytes[0] = 8'hA1; lock_bytes[1] = 8'hA2;
        lock_bytes[2] = 8'hA3; lock_bytes[3] = 8'hA4;
        resp_delay = 6;
        g0 = go_cnt;
        expect_xfer(0, 1'b1, lock_bytes[0]);
        expect_xfer(0, 1'b1, lock_bytes[1]);
        expect_xfer(0, 1'b1, lock_bytes[2]);
        expect_xfer(1, 1'b1, 8'hB1);
        expect_xfer(0, 1'b1, lock_bytes[3]);
        req0_lock = 1'b1;
        set_req(0, 1'b1, lock_bytes[0]);
        @(negedge clk);
        drop_go();
        wait_out(0, 20, "lock_first_go");
        set_req(1, 1'b1, 8'hB1);
        @(negedge clk);
        drop_go();
        for (int k = 0; k < 3; k++) begin
            wait_out(1, 50, "lock_req0_done");
            // Re-request in the DONE cycle; the last one also releases the lock.
            if (k == 2) req0_lock = 1'b0;
            set_req(0, 1'b1, lock_bytes[k + 1]);
            @(negedge clk);
            drop_go();
        end
        wait_idle(200, "lock");
        check("lock_go_count", 32'(go_cnt - g0), 32'(5));

        // ---- duplicate go while pending ----
        resp_delay = 5;
        g0 = go_cnt;
        expect_xfer(0, 1'b1, 8'h33);
        set_req(0, 1'b1, 8'h33);
        @(negedge clk);
        set_req(0, 1'b1, 8'hFF);
        @(negedge clk);
        drop_go();
        wait_idle(200, "duplicate");
        check("duplicate_go_count", 32'(go_cnt - g0), 32'(1));

        // ---- stray uart_done while idle ----
        d0 = done_cnt;
        ud_stray = 1'b1;
        @(negedge clk);
        ud_stray = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_done_busy",  32'(busy), 32'(0));
        check("stray_done_count", 32'(done_cnt - d0), 32'(0));

        // ---- reset while waiting on the UART ----
        resp_delay = 10;
        expect_xfer(1, 1'b1, 8'h99);
        set_req(1, 1'b1, 8'h99);
        @(negedge clk);
        drop_go();
        wait_out(0, 20, "reset_go");
        repeat (2) @(negedge clk);
        check("pre_reset_state", 32'(dbg_state), 32'(WAIT));
        d0 = done_cnt;
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("mid_reset_busy",  32'(busy), 32'(0));
        check("mid_reset_owner", 32'(owner), 32'(1));
        check("mid_reset_txdata", 32'(txdata), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        ord_q.delete();
        rx_q.delete();
        repeat (15) @(negedge clk);
        check("reset_no_done", 32'(done_cnt - d0), 32'(0));
        check("reset_idle_busy", 32'(busy), 32'(0));
        resp_delay = 3;
        expect_xfer(0, 1'b0, 8'h5C);
        set_req(0, 1'b0, 8'h5C);
        @(negedge clk);
        drop_go();
        wait_idle(200, "after_reset");
        check("after_reset_rx", 32'(req0_rxdata), 32'(8'h5C));

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
